// File: rtl/avalon_st_packet_arbiter_if.sv
// Avalon-ST stream bundle shared by the arbiter's requester and merged ports.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_WIDTH = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_WIDTH-1:0]           empty;
  logic                             rdy;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_packet_arbiter.sv
// Packet-level round-robin arbiter merging NUM_INPUTS Avalon-ST sources onto one sink.
// A grant spans sop..eop; stray out-of-packet beats seen while idle are drained and flagged.
module avalon_st_packet_arbiter #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int NUM_INPUTS          = 4,
  parameter int COUNT_WIDTH         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  avalon_st_if.slave                    requesters [NUM_INPUTS],
  avalon_st_if.master                   merged,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_idx,
  output logic                          grant_active,
  output logic                          drop_indc,
  output logic [COUNT_WIDTH-1:0]        packet_count
);
  localparam int IDX_W   = $clog2(NUM_INPUTS);
  localparam int DATA_W  = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, PASS = 1'b1} state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [IDX_W-1:0]       grant_idx_r;
  logic [IDX_W-1:0]       last_grant_r;
  logic [IDX_W-1:0]       pick_s;
  logic                   found_s;
  logic                   drop_s;
  logic                   drop_indc_r;
  logic                   eop_xfer_s;
  logic [COUNT_WIDTH-1:0] packet_count_r;

  logic [DATA_W-1:0]      req_data_s  [NUM_INPUTS];
  logic [EMPTY_W-1:0]     req_empty_s [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  req_valid_s;
  logic [NUM_INPUTS-1:0]  req_sop_s;
  logic [NUM_INPUTS-1:0]  req_eop_s;
  logic [NUM_INPUTS-1:0]  req_rdy_s;
  logic [NUM_INPUTS-1:0]  eligible_s;

  // Interface arrays only take constant indices, so flatten them for muxing.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
    assign req_data_s[i]     = requesters[i].data;
    assign req_empty_s[i]    = requesters[i].empty;
    assign req_valid_s[i]    = requesters[i].valid;
    assign req_sop_s[i]      = requesters[i].sop;
    assign req_eop_s[i]      = requesters[i].eop;
    assign requesters[i].rdy = req_rdy_s[i];
  end

  assign eligible_s = req_valid_s & req_sop_s;

  // Round-robin search for the first eligible input after the last one served.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {IDX_W{1'b0}};
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      if (!found_s && eligible_s[IDX_W'((int'(last_grant_r) + k) % NUM_INPUTS)]) begin
        found_s = 1'b1;
        pick_s  = IDX_W'((int'(last_grant_r) + k) % NUM_INPUTS);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state, output mux and per-input ready generation.
  always_comb begin
    state_next_s = state_r;
    req_rdy_s    = {NUM_INPUTS{1'b0}};
    merged.data  = {DATA_W{1'b0}};
    merged.valid = 1'b0;
    merged.sop   = 1'b0;
    merged.eop   = 1'b0;
    merged.empty = {EMPTY_W{1'b0}};
    drop_s       = 1'b0;
    eop_xfer_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // Mid-packet beats with no owner are drained, even while a grant is being made.
        req_rdy_s = req_valid_s & ~req_sop_s;
        drop_s    = |(req_valid_s & ~req_sop_s);
        if (found_s) begin
          state_next_s = PASS;
        end else begin
          state_next_s = IDLE;
        end
      end
      PASS: begin
        merged.data            = req_data_s[grant_idx_r];
        merged.valid           = req_valid_s[grant_idx_r];
        merged.sop             = req_sop_s[grant_idx_r];
        merged.eop             = req_eop_s[grant_idx_r];
        merged.empty           = req_empty_s[grant_idx_r];
        req_rdy_s[grant_idx_r] = merged.rdy;
        if (req_valid_s[grant_idx_r] && merged.rdy && req_eop_s[grant_idx_r]) begin
          eop_xfer_s   = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = PASS;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, grant bookkeeping, drop flag and packet counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      grant_idx_r    <= {IDX_W{1'b0}};
      last_grant_r   <= IDX_W'(NUM_INPUTS - 1);
      drop_indc_r    <= 1'b0;
      packet_count_r <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_r     <= state_next_s;
      drop_indc_r <= drop_s;
      if (state_r == IDLE && found_s) begin
        grant_idx_r <= pick_s;
      end else begin
        grant_idx_r <= grant_idx_r;
      end
      if (eop_xfer_s) begin
        last_grant_r   <= grant_idx_r;
        packet_count_r <= packet_count_r + COUNT_WIDTH'(1);
      end else begin
        last_grant_r   <= last_grant_r;
        packet_count_r <= packet_count_r;
      end
    end
  end

  assign grant_idx    = grant_idx_r;
  assign grant_active = (state_r == PASS);
  assign drop_indc    = drop_indc_r;
  assign packet_count = packet_count_r;
endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Directed bench for avalon_st_packet_arbiter: vector table plus hand sequences.
module tb_avalon_st_packet_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   in_v, in_s, in_e, rdy_obs;
  logic [127:0] in_data  [4];
  logic [3:0]   in_empty [4];
  logic         m_rdy;
  logic [1:0]   grant_idx;
  logic         grant_active, drop_indc;
  logic [15:0]  packet_count;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) req_if [4] ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) merged_if ();

  for (genvar i = 0; i < 4; i++) begin : g_drv
    assign req_if[i].data  = in_data[i];
    assign req_if[i].valid = in_v[i];
    assign req_if[i].sop   = in_s[i];
    assign req_if[i].eop   = in_e[i];
    assign req_if[i].empty = in_empty[i];
    assign rdy_obs[i]      = req_if[i].rdy;
  end
  assign merged_if.rdy = m_rdy;

  avalon_st_packet_arbiter #(.DATA_WIDTH_IN_BYTES(16), .NUM_INPUTS(4), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .requesters(req_if), .merged(merged_if),
    .grant_idx(grant_idx), .grant_active(grant_active), .drop_indc(drop_indc),
    .packet_count(packet_count));

  // Small instance used to reach the counter wrap quickly.
  logic        w_v;
  logic [31:0] w_data;
  logic [1:0]  w_cnt;
  logic        w_gidx, w_ga, w_drop;
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) w_req [2] ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) w_merged ();
  assign w_req[0].data  = 32'h11223344;
  assign w_req[0].valid = w_v;
  assign w_req[0].sop   = 1'b1;
  assign w_req[0].eop   = 1'b1;
  assign w_req[0].empty = 2'd0;
  assign w_req[1].data  = 32'd0;
  assign w_req[1].valid = 1'b0;
  assign w_req[1].sop   = 1'b0;
  assign w_req[1].eop   = 1'b0;
  assign w_req[1].empty = 2'd0;
  assign w_merged.rdy   = 1'b1;
  assign w_data         = w_merged.data;

  avalon_st_packet_arbiter #(.DATA_WIDTH_IN_BYTES(4), .NUM_INPUTS(2), .COUNT_WIDTH(2)) dut_w (
    .clk(clk), .rst(rst), .requesters(w_req), .merged(w_merged),
    .grant_idx(w_gidx), .grant_active(w_ga), .drop_indc(w_drop), .packet_count(w_cnt));

  int checks = 0;
  int errors = 0;
  int beats  = 0;

  always @(posedge clk) begin
    if (merged_if.valid && m_rdy) beats <= beats + 1;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  v, s, e;
    logic        mr;
    logic [2:0]  m;    // {merged valid, sop, eop}
    logic [3:0]  rdy;
    logic        ga;
    logic [1:0]  gi;
    logic        drop;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                              input logic mr, input logic [2:0] m, input logic [3:0] rdy,
                              input logic ga, input logic [1:0] gi, input logic drop,
                              input logic [15:0] cnt);
    vec_t r;
    r = {v, s, e, mr, m, rdy, ga, gi, drop, cnt};
    return r;
  endfunction

  vec_t tbl [$];

  task automatic clear_inputs();
    in_v = 4'd0; in_s = 4'd0; in_e = 4'd0; m_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data[i]  = 128'd0;
      in_empty[i] = 4'd0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    logic [7:0]   bt;
    logic [127:0] exp_d;
    clear_inputs();
    w_v = 1'b0;
    #12;
    chk("rst_valid", 128'(merged_if.valid), 128'd0);
    chk("rst_ga", 128'(grant_active), 128'd0);
    chk("rst_gi", 128'(grant_idx), 128'd0);
    chk("rst_drop", 128'(drop_indc), 128'd0);
    chk("rst_cnt", 128'(packet_count), 128'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single requester: 3-beat packet on in0, bytes of 34, empty=1 on eop.
    @(negedge clk);
    in_v = 4'b0001; in_s = 4'b0001; in_e = 4'b0000; in_data[0] = {16{8'd34}};
    #2;
    chk("s1_arb_valid", 128'(merged_if.valid), 128'd0);
    chk("s1_arb_rdy", 128'(rdy_obs), 128'd0);
    @(negedge clk); #2;
    chk("s1_sop", 128'({merged_if.valid, merged_if.sop, merged_if.eop}), 128'(3'b110));
    chk("s1_data", merged_if.data, {16{8'd34}});
    chk("s1_gi", 128'({grant_active, grant_idx}), 128'(3'b100));
    chk("s1_rdy", 128'(rdy_obs), 128'(4'b0001));
    @(negedge clk);
    in_s = 4'b0000; #2;
    chk("s1_mid", 128'({merged_if.valid, merged_if.sop, merged_if.eop}), 128'(3'b100));
    @(negedge clk);
    in_e = 4'b0001; in_empty[0] = 4'd1; #2;
    chk("s1_eop", 128'({merged_if.valid, merged_if.eop, merged_if.empty}), 128'({2'b11, 4'd1}));
    @(negedge clk);
    in_v = 4'b0000; in_e = 4'b0000; #2;
    chk("s1_done", 128'({merged_if.valid, grant_active, packet_count}), 128'({2'b00, 16'd1}));

    // Round robin, grant hold, stray beats, back-pressure.
    tbl.push_back(mk(4'b1111, 4'b1111, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd0, 1'b0, 16'd0));
    tbl.push_back(mk(4'b1111, 4'b1111, 4'b0000, 1'b1, 3'b110, 4'b0001, 1'b1, 2'd0, 1'b0, 16'd0));
    tbl.push_back(mk(4'b1111, 4'b1110, 4'b0001, 1'b1, 3'b101, 4'b0001, 1'b1, 2'd0, 1'b0, 16'd0));
    tbl.push_back(mk(4'b1111, 4'b1111, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd0, 1'b0, 16'd1));
    tbl.push_back(mk(4'b1111, 4'b1111, 4'b0000, 1'b1, 3'b110, 4'b0010, 1'b1, 2'd1, 1'b0, 16'd1));
    tbl.push_back(mk(4'b1111, 4'b1101, 4'b0010, 1'b1, 3'b101, 4'b0010, 1'b1, 2'd1, 1'b0, 16'd1));
    tbl.push_back(mk(4'b1101, 4'b1101, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd1, 1'b0, 16'd2));
    tbl.push_back(mk(4'b1101, 4'b1101, 4'b0000, 1'b1, 3'b110, 4'b0100, 1'b1, 2'd2, 1'b0, 16'd2));
    tbl.push_back(mk(4'b1101, 4'b1001, 4'b0100, 1'b1, 3'b101, 4'b0100, 1'b1, 2'd2, 1'b0, 16'd2));
    tbl.push_back(mk(4'b1001, 4'b1001, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd2, 1'b0, 16'd3));
    tbl.push_back(mk(4'b1001, 4'b1001, 4'b0000, 1'b1, 3'b110, 4'b1000, 1'b1, 2'd3, 1'b0, 16'd3));
    tbl.push_back(mk(4'b1001, 4'b0001, 4'b1000, 1'b1, 3'b101, 4'b1000, 1'b1, 2'd3, 1'b0, 16'd3));
    tbl.push_back(mk(4'b0001, 4'b0001, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd3, 1'b0, 16'd4));
    tbl.push_back(mk(4'b0001, 4'b0001, 4'b0001, 1'b1, 3'b111, 4'b0001, 1'b1, 2'd0, 1'b0, 16'd4));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd0, 1'b0, 16'd5));
    tbl.push_back(mk(4'b0110, 4'b0110, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd0, 1'b0, 16'd5));
    tbl.push_back(mk(4'b0110, 4'b0110, 4'b0000, 1'b1, 3'b110, 4'b0010, 1'b1, 2'd1, 1'b0, 16'd5));
    tbl.push_back(mk(4'b0100, 4'b0100, 4'b0000, 1'b1, 3'b000, 4'b0010, 1'b1, 2'd1, 1'b0, 16'd5));
    tbl.push_back(mk(4'b0100, 4'b0100, 4'b0000, 1'b1, 3'b000, 4'b0010, 1'b1, 2'd1, 1'b0, 16'd5));
    tbl.push_back(mk(4'b0110, 4'b0100, 4'b0010, 1'b1, 3'b101, 4'b0010, 1'b1, 2'd1, 1'b0, 16'd5));
    tbl.push_back(mk(4'b0100, 4'b0100, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd1, 1'b0, 16'd6));
    tbl.push_back(mk(4'b0100, 4'b0100, 4'b0100, 1'b1, 3'b111, 4'b0100, 1'b1, 2'd2, 1'b0, 16'd6));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd2, 1'b0, 16'd7));
    tbl.push_back(mk(4'b1000, 4'b0000, 4'b0000, 1'b1, 3'b000, 4'b1000, 1'b0, 2'd2, 1'b0, 16'd7));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd2, 1'b1, 16'd7));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd2, 1'b0, 16'd7));
    tbl.push_back(mk(4'b1001, 4'b0001, 4'b0000, 1'b1, 3'b000, 4'b1000, 1'b0, 2'd2, 1'b0, 16'd7));
    tbl.push_back(mk(4'b1001, 4'b0001, 4'b0001, 1'b1, 3'b111, 4'b0001, 1'b1, 2'd0, 1'b1, 16'd7));
    tbl.push_back(mk(4'b1000, 4'b0000, 4'b0000, 1'b1, 3'b000, 4'b1000, 1'b0, 2'd0, 1'b0, 16'd8));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd0, 1'b1, 16'd8));
    tbl.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd0, 1'b0, 16'd8));
    tbl.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1'b0, 3'b110, 4'b0000, 1'b1, 2'd1, 1'b0, 16'd8));
    tbl.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1'b0, 3'b110, 4'b0000, 1'b1, 2'd1, 1'b0, 16'd8));
    tbl.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1'b0, 3'b110, 4'b0000, 1'b1, 2'd1, 1'b0, 16'd8));
    tbl.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1'b1, 3'b110, 4'b0010, 1'b1, 2'd1, 1'b0, 16'd8));
    tbl.push_back(mk(4'b0010, 4'b0000, 4'b0010, 1'b1, 3'b101, 4'b0010, 1'b1, 2'd1, 1'b0, 16'd8));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 3'b000, 4'b0000, 1'b0, 2'd1, 1'b0, 16'd9));

    do_reset();
    b0 = beats;
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      in_v = tbl[k].v; in_s = tbl[k].s; in_e = tbl[k].e; m_rdy = tbl[k].mr;
      for (int i = 0; i < 4; i++) begin
        in_data[i]  = {16{8'(k * 8 + i)}};
        in_empty[i] = 4'(i + 1);
      end
      #2;
      bt    = 8'(k * 8 + int'(tbl[k].gi));
      exp_d = tbl[k].ga ? {16{bt}} : 128'd0;
      chk($sformatf("v%0d_vse", k), 128'({merged_if.valid, merged_if.sop, merged_if.eop}), 128'(tbl[k].m));
      chk($sformatf("v%0d_data", k), merged_if.data, exp_d);
      chk($sformatf("v%0d_empty", k), 128'(merged_if.empty), tbl[k].ga ? 128'(int'(tbl[k].gi) + 1) : 128'd0);
      chk($sformatf("v%0d_rdy", k), 128'(rdy_obs), 128'(tbl[k].rdy));
      chk($sformatf("v%0d_ga", k), 128'(grant_active), 128'(tbl[k].ga));
      chk($sformatf("v%0d_gi", k), 128'(grant_idx), 128'(tbl[k].gi));
      chk($sformatf("v%0d_drop", k), 128'(drop_indc), 128'(tbl[k].drop));
      chk($sformatf("v%0d_cnt", k), 128'(packet_count), 128'(tbl[k].cnt));
    end
    chk("table_beats", 128'(beats - b0), 128'd15);

    // Reset during beat 2 of an in2 packet; input 0 must win afterwards.
    @(negedge clk);
    in_v = 4'b0100; in_s = 4'b0100; in_e = 4'b0000;
    @(negedge clk); #2;
    chk("rm_sop", 128'({merged_if.valid, merged_if.sop, grant_idx}), 128'({2'b11, 2'd2}));
    @(negedge clk);
    in_v = 4'b0111; in_s = 4'b0011;
    #2;
    chk("rm_beat2", 128'(merged_if.valid), 128'd1);
    rst = 1'b0;
    #1;
    chk("rm_valid", 128'(merged_if.valid), 128'd0);
    chk("rm_ga", 128'(grant_active), 128'd0);
    chk("rm_cnt", 128'(packet_count), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    in_v = 4'b0011; in_s = 4'b0011;
    for (int i = 0; i < 4; i++) in_data[i] = {16{8'(8'hA0 + i)}};
    @(negedge clk); #2;
    chk("rm_regrant", 128'({grant_active, grant_idx}), 128'({1'b1, 2'd0}));
    chk("rm_data", merged_if.data, {16{8'hA0}});
    clear_inputs();

    // Counter wrap on the 2-bit instance: 1, 2, 3, 0, 1.
    @(negedge clk);
    w_v = 1'b1;
    for (int p = 1; p <= 5; p++) begin
      repeat (2) @(negedge clk);
      #2;
      chk($sformatf("wrap%0d", p), 128'(w_cnt), 128'(p % 4));
      chk($sformatf("wrap%0d_ga", p), 128'({w_ga, w_gidx}), 128'd0);
    end
    w_v = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/avalon_st_packet_arbiter.md
Name: avalon_st_packet_arbiter

Overview:
- Packet-level round-robin arbiter/mux for NUM_INPUTS Avalon-ST sources sharing one Avalon-ST sink.
- Sits downstream of per-source avalon_enforcer instances, so inputs are already protocol-clean, and upstream of the shared datapath.
- Grant is held from sop to eop, so packets never interleave.
- Out-of-packet beats seen while arbitrating are discarded and flagged.

Parameters:
- DATA_WIDTH_IN_BYTES, 16, data bus width in bytes; same value on every avalon_st_if port.
- NUM_INPUTS, 4, number of requesters; legal range 2..8.
- COUNT_WIDTH, 16, width of the granted-packet counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- requesters  avalon_st_if.slave  array [NUM_INPUTS]  input streams (data, valid, sop, eop, empty in; rdy out).
- merged  avalon_st_if.master  1  arbitrated output stream (rdy in).
- grant_idx  output  $clog2(NUM_INPUTS)  index of the currently granted input.
- grant_active  output  1  high while in PASS.
- drop_indc  output  1  one-cycle pulse per cycle in which at least one out-of-packet beat was discarded.
- packet_count  output  COUNT_WIDTH  number of eop beats transferred on merged; wraps to 0.

Behaviour:
- Reset (rst=0, async), all registered outputs clear immediately:
  - state = IDLE, grant_idx = 0, grant_active = 0, drop_indc = 0, packet_count = 0.
  - last_grant = NUM_INPUTS-1, so input 0 has first priority.
- Transfer definition: a beat transfers when valid & rdy in the same cycle.
- IDLE state:
  - merged.valid/sop/eop = 0, merged.data = 0, merged.empty = 0.
  - Eligible input: valid & sop.
  - If any input is eligible, register grant_idx = first eligible index searching from last_grant+1 upward, modulo NUM_INPUTS. Next state is PASS.
  - No data moves in the arbitration cycle: rdy = 0 to every eligible input.
  - Inputs with valid & ~sop get rdy = 1 in IDLE; the beat is discarded and drop_indc pulses high on the next cycle (registered). This applies even in the cycle a grant is made.
- PASS state, with g = grant_idx:
  - merged.data/valid/sop/eop/empty mirror requesters[g] combinationally.
  - requesters[g].rdy = merged.rdy; all other inputs get rdy = 0 (stalled, not dropped).
  - When requesters[g] transfers with eop=1: last_grant = g, packet_count += 1, next state is IDLE.
  - Single-beat packets (sop & eop) follow the same path.
  - Valid low mid-packet: the grant is held indefinitely; there is no timeout.
- Throughput: minimum one idle cycle between consecutive packets (arbitration bubble). Packet latency = 1 cycle from sop presentation to sop on merged.
- Fairness: after serving input g, inputs g+1 .. NUM_INPUTS-1, 0 .. g are searched in that order.
- Reset mid-packet: the packet is truncated at merged with no eop. Downstream enforcer handles recovery.
- merged.rdy low in PASS: all inputs stall and the grant is held.
- packet_count wraps from 2^COUNT_WIDTH-1 to 0.

Test Plan:
- Single requester: reset, then in0 sends a 3-beat packet, data 8'd34 per byte, empty=1 on eop, merged.rdy=1 → sop on merged 1 cycle after in0 sop; 3 beats transferred; grant_idx=0; packet_count=1; back to IDLE.
- Round-robin: in0..in3 all hold valid&sop with 2-beat packets → packets appear in order 0,1,2,3, each separated by 1 idle cycle; next round starts at 0; packet_count=4.
- Grant hold: in1 granted; in1 drops valid for 2 cycles mid-packet while in2 has sop pending → no in2 beat on merged until in1 eop; in2 granted next.
- Back-pressure: merged.rdy=0 for 3 cycles during PASS → requesters[g].rdy=0, merged signals stable, no beat lost or duplicated.
- Stray valid: in3 presents valid without sop while the arbiter is IDLE → in3.rdy=1; drop_indc pulses once; nothing on merged; grant unchanged.
- Reset mid-packet: assert rst=0 during beat 2 of an in2 packet → merged.valid=0, grant_active=0, packet_count=0 immediately; after release, input 0 wins the first arbitration.
